// File: rtl/game_display_timing.sv
// game_display_timing: VGA raster generator for pacman_game.
// Free-running H/V counters produce syncs and map the raster onto a centred,
// integer-upscaled game window, emitting registered game-space coordinates
// and strobes. Optional build macro GAME_TIMING_BORDER_EN adds a 'border'
// output flagging the one-pixel ring just outside the game window.
`timescale 1ns/1ps

module game_display_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int GAME_W   = 224,
    parameter int GAME_H   = 288,
    parameter int SCALE    = 1
) (
    input  logic                        vga_pix_clk,
    input  logic                        rst,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        vga_active,
    output logic                        display_enabled,
    output logic [$clog2(GAME_W)-1:0]   sx,
    output logic [$clog2(GAME_H)-1:0]   sy,
    output logic                        game_pix_stb,
    output logic                        frame_stb
`ifdef GAME_TIMING_BORDER_EN
    ,
    output logic                        border
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL + 1);
    localparam int VCW     = $clog2(V_TOTAL + 1);
    localparam int H_OFF   = (H_ACTIVE - GAME_W * SCALE) / 2;
    localparam int V_OFF   = (V_ACTIVE - GAME_H * SCALE) / 2;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int SXW     = $clog2(GAME_W);
    localparam int SYW     = $clog2(GAME_H);
    localparam int GXW     = $clog2(GAME_W + 1);
    localparam int GYW     = $clog2(GAME_H + 1);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_OFF_C  = HCW'(H_OFF);
    localparam logic [VCW-1:0] V_OFF_C  = VCW'(V_OFF);
    localparam logic [HCW-1:0] H_END_C  = HCW'(H_OFF + GAME_W * SCALE);
    localparam logic [VCW-1:0] V_END_C  = VCW'(V_OFF + GAME_H * SCALE);
    localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
    localparam logic [HCW-1:0] HS_LO    = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_HI    = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] VS_LO    = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_HI    = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0]  SUB_LAST = SW'(SCALE - 1);

    // A window that does not fit the active area is a configuration error.
    generate
        if (GAME_W * SCALE > H_ACTIVE || GAME_H * SCALE > V_ACTIVE) begin : g_bad_cfg
            $error("game_display_timing: game window does not fit the active area");
        end
    endgenerate

    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic [SW-1:0]  hsub_q, hsub_d, vsub_q, vsub_d;
    logic [GXW-1:0] gx_q, gx_d;
    logic [GYW-1:0] gy_q, gy_d;

    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic           active_q, active_d, de_q, de_d;
    logic [SXW-1:0] sx_q, sx_d;
    logic [SYW-1:0] sy_q, sy_d;
    logic           pix_stb_q, pix_stb_d, frame_stb_q, frame_stb_d;

    logic h_in, v_in, in_win, active_now;

    assign h_in       = (hc_q >= H_OFF_C) && (hc_q < H_END_C);
    assign v_in       = (vc_q >= V_OFF_C) && (vc_q < V_END_C);
    assign in_win     = h_in && v_in;
    assign active_now = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);

    // Raster counters plus the scale sub-counters that derive game x/y;
    // sub-counters restart when the raster re-enters the window edge.
    always_comb begin
        hc_d   = (hc_q == H_LAST) ? '0 : hc_q + 1'b1;
        vc_d   = vc_q;
        hsub_d = hsub_q;
        gx_d   = gx_q;
        vsub_d = vsub_q;
        gy_d   = gy_q;
        if (hc_q == H_LAST) begin
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
        if (hc_d == H_OFF_C) begin
            hsub_d = '0;
            gx_d   = '0;
        end else if (h_in) begin
            if (hsub_q == SUB_LAST) begin
                hsub_d = '0;
                gx_d   = gx_q + 1'b1;
            end else begin
                hsub_d = hsub_q + 1'b1;
            end
        end
        if (hc_q == H_LAST) begin
            if (vc_d == V_OFF_C) begin
                vsub_d = '0;
                gy_d   = '0;
            end else if (v_in) begin
                if (vsub_q == SUB_LAST) begin
                    vsub_d = '0;
                    gy_d   = gy_q + 1'b1;
                end else begin
                    vsub_d = vsub_q + 1'b1;
                end
            end
        end
    end

    // Output decode from the current counter state, registered one cycle later.
    always_comb begin
        hsync_d     = ((hc_q >= HS_LO) && (hc_q < HS_HI)) ? SYNC_POL : ~SYNC_POL;
        vsync_d     = ((vc_q >= VS_LO) && (vc_q < VS_HI)) ? SYNC_POL : ~SYNC_POL;
        active_d    = active_now;
        de_d        = in_win;
        sx_d        = in_win ? gx_q[SXW-1:0] : '0;
        sy_d        = in_win ? gy_q[SYW-1:0] : '0;
        pix_stb_d   = in_win && (hsub_q == '0);
        frame_stb_d = in_win && (hc_q == H_OFF_C) && (vc_q == V_OFF_C);
    end

    // State and output registers with synchronous reset to the raster origin.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            hc_q        <= '0;
            vc_q        <= '0;
            hsub_q      <= '0;
            vsub_q      <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            active_q    <= 1'b0;
            de_q        <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            pix_stb_q   <= 1'b0;
            frame_stb_q <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            hsub_q      <= hsub_d;
            vsub_q      <= vsub_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            de_q        <= de_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            pix_stb_q   <= pix_stb_d;
            frame_stb_q <= frame_stb_d;
        end
    end

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign vga_active      = active_q;
    assign display_enabled = de_q;
    assign sx              = sx_q;
    assign sy              = sy_q;
    assign game_pix_stb    = pix_stb_q;
    assign frame_stb       = frame_stb_q;

`ifdef GAME_TIMING_BORDER_EN
    localparam logic [HCW-1:0] H_RING_LO = HCW'((H_OFF > 0) ? H_OFF - 1 : 0);
    localparam logic [VCW-1:0] V_RING_LO = VCW'((V_OFF > 0) ? V_OFF - 1 : 0);

    logic border_q, border_d;
    logic ring_now;

    assign ring_now = (hc_q >= H_RING_LO) && (hc_q <= H_END_C) &&
                      (vc_q >= V_RING_LO) && (vc_q <= V_END_C);

    // One-pixel ring just outside the window, limited to the visible area.
    always_comb begin
        border_d = active_now && ring_now && !in_win;
    end

    // Border flag shares the output latency of the other registered outputs.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            border_q <= 1'b0;
        end else begin
            border_q <= border_d;
        end
    end

    assign border = border_q;
`endif

endmodule
